// File: rtl/seg7_bank_if.sv
// seg7_bank_if: load/scroll/blink controls and segment outputs
// for the seg7_bank display driver.
interface seg7_bank_if #(
    parameter int DIGITS = 6
);
    logic                  load;
    logic [4*DIGITS-1:0]   codes;
    logic [DIGITS-1:0]     en_mask;
    logic                  scroll;
    logic [DIGITS-1:0]     blink_mask;
    logic [7*DIGITS-1:0]   leds;
    logic                  wrap;

    modport master (
        output load, codes, en_mask, scroll, blink_mask,
        input  leds, wrap
    );

    modport slave (
        input  load, codes, en_mask, scroll, blink_mask,
        output leds, wrap
    );
endinterface

// File: rtl/seg7_bank.sv
// seg7_bank: multi-digit 7-segment driver with marquee scroll.
// Optional blink support is built when SEG7_BLINK_EN is defined.
module seg7_bank #(
    parameter int DIGITS     = 6,
    parameter int SCROLL_DIV = 25000000,
    parameter int BLINK_DIV  = 12500000
) (
    input  logic      clk,
    input  logic      reset,
    seg7_bank_if.slave bus
);
    localparam int OW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SW = $clog2(SCROLL_DIV);

    typedef enum logic {SHOW, SCROLL} state_t;

    state_t              state_q, state_d;
    logic [OW-1:0]       offset_q, offset_d;
    logic [SW-1:0]       scnt_q, scnt_d;
    logic [4*DIGITS-1:0] codes_q, codes_d;
    logic [DIGITS-1:0]   en_q, en_d;
    logic [7*DIGITS-1:0] leds_q, leds_d;
    logic                wrap_q, wrap_d;
    logic [DIGITS-1:0]   blank;

    function automatic logic [6:0] glyph(input logic [3:0] c);
        logic [6:0] g;
        unique case (c)
            4'h0:    g = 7'b0010010;
            4'h1:    g = 7'b1000010;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            4'hF:    g = 7'b0001110;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

`ifdef SEG7_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV);

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;

    // Free-running blink divider; phase flips at terminal count.
    always_comb begin
        bcnt_d  = bcnt_q + BW'(1);
        phase_d = phase_q;
        if (bcnt_q == BW'(BLINK_DIV - 1)) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end
    end

    // Blink divider registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end

    assign blank = phase_q ? bus.blink_mask : '0;
`else
    logic unused_blink;
    assign unused_blink = (^bus.blink_mask) ^ BLINK_DIV[0];
    assign blank = '0;
`endif

    // Mode, scroll offset, shadow capture and wrap pulse.
    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        scnt_d   = scnt_q;
        codes_d  = codes_q;
        en_d     = en_q;
        wrap_d   = 1'b0;
        unique case (state_q)
            SHOW: begin
                if (bus.scroll) state_d = SCROLL;
            end
            SCROLL: begin
                if (!bus.scroll) begin
                    state_d  = SHOW;
                    offset_d = '0;
                    scnt_d   = '0;
                end else if (scnt_q == SW'(SCROLL_DIV - 1)) begin
                    scnt_d = '0;
                    if (offset_q == OW'(DIGITS - 1)) begin
                        offset_d = '0;
                        wrap_d   = 1'b1;
                    end else begin
                        offset_d = offset_q + OW'(1);
                    end
                end else begin
                    scnt_d = scnt_q + SW'(1);
                end
            end
            default: state_d = SHOW;
        endcase
        // A new load restarts the marquee from slot 0.
        if (bus.load) begin
            codes_d  = bus.codes;
            en_d     = bus.en_mask;
            offset_d = '0;
            scnt_d   = '0;
            wrap_d   = 1'b0;
        end
    end

    // Segment pattern per displayed digit from rotated shadow slot.
    always_comb begin
        int slot;
        leds_d = '1;
        slot   = 0;
        for (int i = 0; i < DIGITS; i++) begin
            slot = i + int'(offset_q);
            if (slot >= DIGITS) slot = slot - DIGITS;
            if (!en_q[slot] || blank[i])
                leds_d[7*i +: 7] = 7'h7F;
            else
                leds_d[7*i +: 7] = glyph(codes_q[4*slot +: 4]);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= SHOW;
            offset_q <= '0;
            scnt_q   <= '0;
            codes_q  <= {DIGITS{4'h8}};
            en_q     <= '0;
            leds_q   <= '1;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            scnt_q   <= scnt_d;
            codes_q  <= codes_d;
            en_q     <= en_d;
            leds_q   <= leds_d;
            wrap_q   <= wrap_d;
        end
    end

    assign bus.leds = leds_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_seg7_bank.sv
// tb_seg7_bank: randomized checks of seg7_bank against a
// cycle-count based reference model.
`timescale 1ns/1ps
module tb_seg7_bank;
    localparam int D  = 6;
    localparam int SD = 4;
    localparam int BD = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seg7_bank_if #(.DIGITS(D)) bus ();

    seg7_bank #(
        .DIGITS(D), .SCROLL_DIV(SD), .BLINK_DIV(BD)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] lut [16];
    int         m_code [D];
    bit         m_en [D];
    bit         m_scr;
    int         m_n;
    int         m_t;
    logic [7*D-1:0] m_leds;
    bit         m_wrap;
    bit         blink_on;

    task automatic model_reset();
        for (int j = 0; j < D; j++) begin
            m_code[j] = 8;
            m_en[j]   = 1'b0;
        end
        m_scr  = 1'b0;
        m_n    = 0;
        m_t    = 0;
        m_leds = '1;
        m_wrap = 1'b0;
    endtask

    // Advance one clock; model offset = (scroll cycles / SD) mod D.
    task automatic step();
        logic [7*D-1:0] nl;
        bit nw;
        int off, s, ph;
        off = (m_n / SD) % D;
        ph  = (m_t / BD) % 2;
        for (int i = 0; i < D; i++) begin
            s = (i + off) % D;
            if (!m_en[s] || (blink_on && ph == 1 && bus.blink_mask[i]))
                nl[7*i +: 7] = 7'h7F;
            else
                nl[7*i +: 7] = lut[m_code[s]];
        end
        nw = 1'b0;
        if (m_scr) begin
            if (bus.scroll) begin
                m_n++;
                nw = (m_n % (SD * D) == 0);
            end else begin
                m_scr = 1'b0;
                m_n   = 0;
            end
        end else if (bus.scroll) begin
            m_scr = 1'b1;
        end
        if (bus.load) begin
            for (int j = 0; j < D; j++) begin
                m_code[j] = int'(bus.codes[4*j +: 4]);
                m_en[j]   = bus.en_mask[j];
            end
            m_n = 0;
            nw  = 1'b0;
        end
        m_t++;
        @(posedge clk);
        #1;
        m_leds = nl;
        m_wrap = nw;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        bus.load = 0; bus.codes = '0; bus.en_mask = '0;
        bus.scroll = 0; bus.blink_mask = '0;
        reset = 1'b1;
        #12;
        n_cmp++;
        if (bus.leds !== '1 || bus.wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: leds=%h wrap=%b want all1/0",
                     bus.leds, bus.wrap);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (3) begin
            step();
            n_cmp++;
            if (bus.leds !== '1 || bus.wrap !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_idle: leds=%h wrap=%b want all1/0",
                         bus.leds, bus.wrap);
            end
        end
    endtask

    task automatic test_load();
        bus.codes = 24'h10ACE2; bus.en_mask = 6'h3F; bus.load = 1;
        step();
        bus.load = 0;
        n_cmp++;
        if (bus.leds !== '1) begin
            n_bad++;
            $display("FAIL load_latency: leds=%h want all1", bus.leds);
        end
        step();
        n_cmp++;
        if (bus.leds[6:0] !== 7'b0100100 || bus.leds[41:35] !== 7'b1000010) begin
            n_bad++;
            $display("FAIL load_glyph: d0=%b d5=%b want 0100100/1000010",
                     bus.leds[6:0], bus.leds[41:35]);
        end
        n_cmp++;
        if (bus.leds !== m_leds) begin
            n_bad++;
            $display("FAIL load_all: leds=%h want %h", bus.leds, m_leds);
        end
    endtask

    task automatic test_scroll();
        int wraps, last, cyc;
        bus.codes = {$urandom, $urandom} & 24'hFFFFFF;
        bus.en_mask = 6'($urandom) | 6'h21;
        bus.load = 1;
        step();
        bus.load = 0;
        bus.scroll = 1;
        wraps = 0; last = -1;
        for (cyc = 0; cyc < 80; cyc++) begin
            step();
            n_cmp++;
            if (bus.leds !== m_leds || bus.wrap !== m_wrap) begin
                n_bad++;
                $display("FAIL scroll_c%0d: leds=%h wrap=%b want %h/%b",
                         cyc, bus.leds, bus.wrap, m_leds, m_wrap);
            end
            if (bus.wrap === 1'b1) begin
                if (last >= 0) begin
                    n_cmp++;
                    if (cyc - last != SD * D) begin
                        n_bad++;
                        $display("FAIL wrap_gap: got %0d want %0d",
                                 cyc - last, SD * D);
                    end
                end
                last = cyc;
                wraps++;
            end
        end
        n_cmp++;
        if (wraps != 3) begin
            n_bad++;
            $display("FAIL wrap_count: got %0d want 3", wraps);
        end
        bus.scroll = 0;
        repeat (2) begin
            step();
            n_cmp++;
            if (bus.leds !== m_leds || bus.wrap !== m_wrap) begin
                n_bad++;
                $display("FAIL scroll_stop: leds=%h wrap=%b want %h/%b",
                         bus.leds, bus.wrap, m_leds, m_wrap);
            end
        end
    endtask

    task automatic test_load_collision();
        int k;
        bus.scroll = 1;
        k = 0;
        while (!(m_scr && m_n % SD == SD - 1 && (m_n / SD) % D == D - 1)
               && k < 200) begin
            step();
            k++;
        end
        n_cmp++;
        if (k >= 200) begin
            n_bad++;
            $display("FAIL collide_reach: got %0d cycles want <200", k);
        end
        bus.codes = {$urandom, $urandom} & 24'hFFFFFF;
        bus.en_mask = 6'h3F;
        bus.load = 1;
        step();
        bus.load = 0;
        n_cmp++;
        if (bus.wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL collide_wrap: wrap=%b want 0", bus.wrap);
        end
        repeat (3) begin
            step();
            n_cmp++;
            if (bus.leds !== m_leds || bus.wrap !== 1'b0) begin
                n_bad++;
                $display("FAIL collide_off0: leds=%h wrap=%b want %h/0",
                         bus.leds, bus.wrap, m_leds);
            end
        end
        bus.scroll = 0;
        step();
    endtask

    task automatic test_dark();
        bus.codes = {$urandom, $urandom} & 24'hFFFFFF;
        bus.en_mask = 6'h00;
        bus.load = 1;
        step();
        bus.load = 0;
        bus.scroll = 1;
        step();
        for (int c = 0; c < 40; c++) begin
            step();
            n_cmp++;
            if (bus.leds !== '1) begin
                n_bad++;
                $display("FAIL dark_c%0d: leds=%h want all1", c, bus.leds);
            end
        end
        bus.scroll = 0;
        step();
    endtask

    task automatic test_blink();
        int blanks, steady_bad;
        logic [6:0] g0;
        logic [35:0] rest;
        bus.codes = ({$urandom, $urandom} & 24'hFFFFF0) | 24'h2;
        bus.en_mask = 6'h3F;
        bus.load = 1;
        step();
        bus.load = 0;
        step();
        g0 = bus.leds[6:0];
        rest = bus.leds[41:7];
        bus.blink_mask = 6'h01;
        step();
        blanks = 0; steady_bad = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            n_cmp++;
            if (bus.leds !== m_leds) begin
                n_bad++;
                $display("FAIL blink_c%0d: leds=%h want %h",
                         c, bus.leds, m_leds);
            end
            if (bus.leds[6:0] === 7'h7F) blanks++;
            else if (bus.leds[6:0] !== 7'b0100100) steady_bad++;
            if (bus.leds[41:7] !== rest) steady_bad++;
        end
        n_cmp++;
        if (blanks != (blink_on ? 6 : 0) || steady_bad != 0
            || g0 !== 7'b0100100) begin
            n_bad++;
            $display("FAIL blink_count: blanks=%0d bad=%0d want %0d/0",
                     blanks, steady_bad, blink_on ? 6 : 0);
        end
        bus.blink_mask = '0;
    endtask

    task automatic test_reset_mid_scroll();
        int k;
        bus.codes = 24'h7654A2; bus.en_mask = 6'h3F; bus.load = 1;
        step();
        bus.load = 0;
        bus.scroll = 1;
        k = 0;
        while (((m_n / SD) % D != 3) && k < 100) begin
            step();
            k++;
        end
        step();
        n_cmp++;
        if (bus.leds !== m_leds) begin
            n_bad++;
            $display("FAIL midscroll_off3: leds=%h want %h",
                     bus.leds, m_leds);
        end
        #1;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.leds !== '1 || bus.wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: leds=%h wrap=%b want all1/0",
                     bus.leds, bus.wrap);
        end
        bus.scroll = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        bus.codes = 24'h7654A2; bus.en_mask = 6'h3F; bus.load = 1;
        step();
        bus.load = 0;
        step();
        n_cmp++;
        if (bus.leds[6:0] !== 7'b0100100 || bus.leds !== m_leds) begin
            n_bad++;
            $display("FAIL post_reset_off0: leds=%h want %h",
                     bus.leds, m_leds);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef SEG7_BLINK_EN
        blink_on = 1'b1;
`else
        blink_on = 1'b0;
`endif
        lut[0]  = 7'b0010010; lut[1]  = 7'b1000010;
        lut[2]  = 7'b0100100; lut[3]  = 7'b0110000;
        lut[4]  = 7'b0011001; lut[5]  = 7'b0010010;
        lut[6]  = 7'b0000010; lut[7]  = 7'b1111000;
        lut[8]  = 7'b1111111; lut[9]  = 7'b1111111;
        lut[10] = 7'b0001000; lut[11] = 7'b0000011;
        lut[12] = 7'b1000110; lut[13] = 7'b0100001;
        lut[14] = 7'b0000110; lut[15] = 7'b0001110;
        model_reset();
        test_reset();
        test_load();
        test_scroll();
        test_load_collision();
        test_dark();
        do_reset();
        test_blink();
        test_reset_mid_scroll();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
